// File: rtl/rst_seq_if.sv
// rst_seq_if: lock/soft-reset inputs and staged reset outputs of the reset sequencer
interface rst_seq_if #(
    parameter int LOSS_CNT_W = 8
);
    logic                  i_locked;
    logic                  i_sw_rst;
    logic                  o_rst_core;
    logic                  o_rst_periph;
    logic                  o_ready;
    logic [2:0]            o_state;
    logic [LOSS_CNT_W-1:0] o_lock_loss_cnt;

    modport master (
        output i_locked, i_sw_rst,
        input  o_rst_core, o_rst_periph, o_ready, o_state, o_lock_loss_cnt
    );

    modport slave (
        input  i_locked, i_sw_rst,
        output o_rst_core, o_rst_periph, o_ready, o_state, o_lock_loss_cnt
    );
endinterface

// File: rtl/rst_seq.sv
// rst_seq: staged core/peripheral reset release after MMCM lock is stable, with lock-loss and soft-reset handling
module rst_seq #(
    parameter int SYNC_STAGES           = 2,
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int CORE_TO_PERIPH_CYCLES = 16,
    parameter int SW_RST_CYCLES         = 8,
    parameter int LOSS_CNT_W            = 8
) (
    input logic      i_clk,
    input logic      i_reset,
    rst_seq_if.slave b
);
    localparam int MAX_A   = LOCK_STABLE_CYCLES > CORE_TO_PERIPH_CYCLES ? LOCK_STABLE_CYCLES : CORE_TO_PERIPH_CYCLES;
    localparam int MAX_CNT = MAX_A > SW_RST_CYCLES ? MAX_A : SW_RST_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_CORE  = 3'd2,
        RUN       = 3'd3,
        SW_RST    = 3'd4
    } state_t;

    state_t                 state, nxt;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   locked_s;
    logic                   loss;

    assign locked_s = sync[SYNC_STAGES-1];

    // bring the asynchronous lock indication into the generated clock domain
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) sync <= '0;
        else         sync <= {sync[SYNC_STAGES-2:0], b.i_locked};

    // next state; lock loss outranks the software request
    always_comb begin
        loss = !locked_s && (state == REL_CORE || state == RUN || state == SW_RST);
        case (state)
            WAIT_LOCK: nxt = locked_s ? STABLE : WAIT_LOCK;
            STABLE:    nxt = !locked_s ? WAIT_LOCK : (cnt == CW'(LOCK_STABLE_CYCLES - 1)) ? REL_CORE : STABLE;
            REL_CORE:  nxt = loss ? WAIT_LOCK : (cnt == CW'(CORE_TO_PERIPH_CYCLES - 1)) ? RUN : REL_CORE;
            RUN:       nxt = loss ? WAIT_LOCK : b.i_sw_rst ? SW_RST : RUN;
            SW_RST:    nxt = loss ? WAIT_LOCK : (cnt == CW'(SW_RST_CYCLES - 1)) ? REL_CORE : SW_RST;
            default:   nxt = WAIT_LOCK;
        endcase
    end

    // state, shared counter and outputs decoded from next state so they move on the same edge
    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state             <= WAIT_LOCK;
            cnt               <= '0;
            b.o_rst_core      <= 1'b1;
            b.o_rst_periph    <= 1'b1;
            b.o_ready         <= 1'b0;
            b.o_state         <= 3'd0;
            b.o_lock_loss_cnt <= '0;
        end else begin
            state             <= nxt;
            cnt               <= (nxt != state || state == WAIT_LOCK || state == RUN) ? '0 : cnt + 1'b1;
            b.o_rst_core      <= !(nxt == REL_CORE || nxt == RUN);
            b.o_rst_periph    <= nxt != RUN;
            b.o_ready         <= nxt == RUN;
            b.o_state         <= nxt;
            if (loss && b.o_lock_loss_cnt != LOSS_MAX)
                b.o_lock_loss_cnt <= b.o_lock_loss_cnt + 1'b1;
        end
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed vector table plus hand-written corner sequences for rst_seq
module tb_rst_seq;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    bit   seen4 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rst_seq_if #(.LOSS_CNT_W(2)) bus ();

    rst_seq #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYCLES(8),
        .CORE_TO_PERIPH_CYCLES(4),
        .SW_RST_CYCLES(3),
        .LOSS_CNT_W(2)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .b(bus.slave)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       l;
        logic       s;
        logic [7:0] e;
    } vec_t;

    vec_t tbl[$];

    wire [7:0] got = {bus.o_rst_core, bus.o_rst_periph, bus.o_ready, bus.o_state, bus.o_lock_loss_cnt};

    function automatic logic [7:0] o(logic c, logic p, logic r, logic [2:0] st, logic [1:0] lc);
        return {c, p, r, st, lc};
    endfunction

    task automatic chk(string n, logic [7:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got core/periph/ready/state/loss=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d/%0d",
                     n, got[7], got[6], got[5], got[4:2], got[1:0], e[7], e[6], e[5], e[4:2], e[1:0]);
        end
    endtask

    task automatic cyc(logic l, logic s);
        bus.i_locked = l;
        bus.i_sw_rst = s;
        @(posedge i_clk);
        @(negedge i_clk);
        if (bus.o_state == 3'd4) seen4 = 1'b1;
    endtask

    task automatic restart();
        @(negedge i_clk);
        i_reset = 1'b1;
        bus.i_locked = 1'b1;
        bus.i_sw_rst = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        seen4 = 1'b0;
    endtask

    task automatic add(logic l, logic s, logic [7:0] e);
        tbl.push_back('{l: l, s: s, e: e});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_locked = 1'b1;
        bus.i_sw_rst = 1'b0;
        for (int e = 0; e < 2; e++)   add(1, 0, o(1, 1, 0, 0, 0));
        for (int e = 2; e < 10; e++)  add(1, 0, o(1, 1, 0, 1, 0));
        for (int e = 10; e < 14; e++) add(1, 0, o(0, 1, 0, 2, 0));
        for (int e = 14; e < 16; e++) add(1, 0, o(0, 0, 1, 3, 0));
        add(1, 1, o(1, 1, 0, 4, 0));
        for (int e = 17; e < 19; e++) add(1, 0, o(1, 1, 0, 4, 0));
        for (int e = 19; e < 23; e++) add(1, 0, o(0, 1, 0, 2, 0));
        for (int e = 23; e < 25; e++) add(1, 0, o(0, 0, 1, 3, 0));
        for (int e = 25; e < 27; e++) add(0, 0, o(0, 0, 1, 3, 0));
        for (int e = 27; e < 29; e++) add(0, 0, o(1, 1, 0, 0, 1));

        #12;
        chk("reset_state", o(1, 1, 0, 0, 0));
        restart();
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].l, tbl[i].s);
            chk($sformatf("vec%0d", i), tbl[i].e);
        end

        restart();
        for (int e = 0; e <= 20; e++) begin
            cyc(e != 5, 0);
            if (e == 6)  chk("glitch_e6",  o(1, 1, 0, 1, 0));
            if (e == 7)  chk("glitch_e7",  o(1, 1, 0, 0, 0));
            if (e == 8)  chk("glitch_e8",  o(1, 1, 0, 1, 0));
            if (e == 15) chk("glitch_e15", o(1, 1, 0, 1, 0));
            if (e == 16) chk("glitch_e16", o(0, 1, 0, 2, 0));
            if (e == 20) chk("glitch_e20", o(0, 0, 1, 3, 0));
        end

        restart();
        for (int e = 0; e <= 14; e++) begin
            cyc(1, e == 5 || e == 11);
            if (e == 5)  chk("swign_e5",  o(1, 1, 0, 1, 0));
            if (e == 10) chk("swign_e10", o(0, 1, 0, 2, 0));
            if (e == 11) chk("swign_e11", o(0, 1, 0, 2, 0));
            if (e == 13) chk("swign_e13", o(0, 1, 0, 2, 0));
            if (e == 14) chk("swign_e14", o(0, 0, 1, 3, 0));
        end

        restart();
        for (int e = 0; e < 16; e++) cyc(1, 0);
        cyc(0, 0);
        cyc(0, 0);
        chk("simul_pre", o(0, 0, 1, 3, 0));
        cyc(0, 1);
        chk("simul_edge", o(1, 1, 0, 0, 1));
        cyc(0, 0);
        chk("simul_after", o(1, 1, 0, 0, 1));
        checks++;
        if (seen4) begin
            errors++;
            $display("FAIL simul_no_swrst: got state 4 observed expected never");
        end

        for (int k = 2; k <= 5; k++) begin
            for (int e = 0; e < 15; e++) cyc(1, 0);
            chk($sformatf("relock%0d", k), o(0, 0, 1, 3, 2'(k - 1 > 3 ? 3 : k - 1)));
            for (int e = 0; e < 3; e++) cyc(0, 0);
            chk($sformatf("loss%0d", k), o(1, 1, 0, 0, 2'(k > 3 ? 3 : k)));
        end

        for (int e = 0; e < 15; e++) cyc(1, 0);
        chk("run_before_async", o(0, 0, 1, 3, 3));
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1 chk("async_reset", o(1, 1, 0, 0, 0));
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int e = 0; e <= 14; e++) begin
            cyc(1, 0);
            if (e == 1)  chk("post_e1",  o(1, 1, 0, 0, 0));
            if (e == 9)  chk("post_e9",  o(1, 1, 0, 1, 0));
            if (e == 10) chk("post_e10", o(0, 1, 0, 2, 0));
            if (e == 14) chk("post_e14", o(0, 0, 1, 3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
